lpc_adaptive_quantizer: RTL and testbench



---
 rtl/lpc_quant_pkg.sv | 22 ++
 rtl/lpc_adaptive_quantizer_if.sv | 29 ++
 rtl/float_to_fixed_scaled.sv | 167 ++++++++++++++++
 rtl/lpc_adaptive_quantizer.sv | 140 ++++++++++++++
 tb/tb_lpc_adaptive_quantizer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/lpc_quant_pkg.sv
// Shared constants for the adaptive LPC coefficient quantizer:
// IEEE-754 single field layout, FSM state codes, output clamp limits.
package lpc_quant_pkg;

    localparam int EXP_W       = 8;
    localparam int MANT_FRAC_W = 23;
    localparam int EXP_BIAS    = 127;
    localparam int EXP_SPECIAL = (1 << EXP_W) - 1;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    function automatic int satMax(input int p);
        return (1 << (p - 1)) - 1;
    endfunction

    function automatic int satMin(input int p);
        return -(1 << (p - 1));
    endfunction

endpackage

// File: rtl/lpc_adaptive_quantizer_if.sv
// Coefficient stream into the quantizer and quantized stream out of it.
// master drives floats (solver side), slave is the quantizer.
interface lpc_adaptive_quantizer_if #(
    parameter int PRECISION = 12
);

    logic                        iValid;
    logic [31:0]                 iFloatCoeff;
    logic [5:0]                  iOrder;
    logic                        oReady;
    logic signed [PRECISION-1:0] oQuantizedCoeff;
    logic [4:0]                  oShift;
    logic                        oValid;
    logic                        oLast;
    logic                        oSaturated;

    modport master (
        output iValid, iFloatCoeff, iOrder,
        input  oReady, oQuantizedCoeff, oShift,
        input  oValid, oLast, oSaturated
    );

    modport slave (
        input  iValid, iFloatCoeff, iOrder,
        output oReady, oQuantizedCoeff, oShift,
        output oValid, oLast, oSaturated
    );

endinterface

// File: rtl/float_to_fixed_scaled.sv
// Float -> scaled fixed point, round half away from zero, saturate; 2 stages.
// LPC_QUANT_ERROR_FEEDBACK_EN adds the carried rounding-error register.
module float_to_fixed_scaled
    import lpc_quant_pkg::*;
#(
    parameter int PRECISION = 12,
    parameter int FRAC_BITS = 8
) (
    input  logic                        iClock,
    input  logic                        iReset,
    input  logic                        iEnable,
`ifdef LPC_QUANT_ERROR_FEEDBACK_EN
    input  logic                        iClear,
`endif
    input  logic                        iValid,
    input  logic                        iLast,
    input  logic [31:0]                 iFloat,
    input  logic [4:0]                  iShift,
    output logic                        oValid,
    output logic                        oLast,
    output logic signed [PRECISION-1:0] oValue,
    output logic                        oSaturated
);

    localparam int MANT_W = MANT_FRAC_W + 1;
    localparam int MAGW   = PRECISION + FRAC_BITS + 1;
    localparam int WW     = MANT_W + MAGW;
    localparam int AW     = MAGW + 3;

    localparam logic signed [AW-1:0] HALF = AW'(1 << (FRAC_BITS - 1));
    localparam logic signed [AW-1:0] QMAX = AW'(satMax(PRECISION));
    localparam logic signed [AW-1:0] QMIN = AW'(satMin(PRECISION));

    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    int                sh;
    int                rsh;
    logic [WW-1:0]     wide;
    logic              ovf;
    logic [MAGW-1:0]   magN;

    assign exp  = iFloat[MANT_FRAC_W +: EXP_W];
    assign mant = {1'b1, iFloat[MANT_FRAC_W-1:0]};

    // Magnitude with FRAC_BITS fraction; overflow pins to all-ones so it saturates.
    always_comb begin
        sh   = int'(exp) + int'(iShift) + FRAC_BITS - (EXP_BIAS + MANT_FRAC_W);
        rsh  = -sh;
        wide = '0;
        ovf  = 1'b0;
        if (sh > MAGW)
            ovf = 1'b1;
        else if (sh >= 0)
            wide = WW'(mant) << sh;
        else if (rsh <= MANT_W + FRAC_BITS)
            wide = WW'(mant) >> rsh;
        ovf  = ovf | (|wide[WW-1:MAGW]);
        magN = ovf ? '1 : wide[MAGW-1:0];
        if (exp == '0)
            magN = '0;
    end

    logic            s1Valid;
    logic            s1Last;
    logic            s1Sign;
    logic            s1Special;
    logic [MAGW-1:0] s1Mag;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            s1Valid   <= 1'b0;
            s1Last    <= 1'b0;
            s1Sign    <= 1'b0;
            s1Special <= 1'b0;
            s1Mag     <= '0;
        end else if (iEnable) begin
            s1Valid   <= iValid;
            s1Last    <= iLast;
            s1Sign    <= iFloat[31];
            s1Special <= (int'(exp) == EXP_SPECIAL);
            s1Mag     <= magN;
        end
    end

    logic signed [AW-1:0] errTerm;
    logic signed [AW-1:0] signedMag;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] absAcc;
    logic signed [AW-1:0] qAbs;
    logic signed [AW-1:0] q;
    logic signed [AW-1:0] qc;
    logic                 sat;

    always_comb begin
        signedMag = $signed({3'b000, s1Mag});
        if (s1Sign)
            signedMag = -signedMag;
        acc    = signedMag + errTerm;
        absAcc = acc[AW-1] ? -acc : acc;
        qAbs   = (absAcc + HALF) >>> FRAC_BITS;
        q      = acc[AW-1] ? -qAbs : qAbs;
        sat    = 1'b1;
        if (s1Special)
            qc = s1Sign ? QMIN : QMAX;
        else if (q > QMAX)
            qc = QMAX;
        else if (q < QMIN)
            qc = QMIN;
        else begin
            qc  = q;
            sat = 1'b0;
        end
    end

`ifdef LPC_QUANT_ERROR_FEEDBACK_EN
    localparam logic signed [AW-1:0] ELIM = AW'((1 << MAGW) - 1);

    logic signed [AW-1:0] err;
    logic signed [AW-1:0] errNext;
    logic signed [AW:0]   qcScaled;
    logic signed [AW:0]   errFull;

    // Clamp keeps repeated saturation from growing the carry without bound.
    always_comb begin
        qcScaled = $signed({qc[AW-1], qc}) <<< FRAC_BITS;
        errFull  = $signed({acc[AW-1], acc}) - qcScaled;
        if (s1Special)
            errNext = '0;
        else if (errFull > ELIM)
            errNext = ELIM;
        else if (errFull < -ELIM)
            errNext = -ELIM;
        else
            errNext = errFull[AW-1:0];
    end

    always_ff @(posedge iClock) begin
        if (iReset)
            err <= '0;
        else if (iEnable) begin
            if (iClear)
                err <= '0;
            else if (s1Valid)
                err <= errNext;
        end
    end

    assign errTerm = err;
`else
    assign errTerm = '0;
`endif

    always_ff @(posedge iClock) begin
        if (iReset) begin
            oValid     <= 1'b0;
            oLast      <= 1'b0;
            oValue     <= '0;
            oSaturated <= 1'b0;
        end else if (iEnable) begin
            oValid     <= s1Valid;
            oLast      <= s1Valid & s1Last;
            oValue     <= s1Valid ? qc[PRECISION-1:0] : '0;
            oSaturated <= s1Valid & sat;
        end
    end

endmodule

// File: rtl/lpc_adaptive_quantizer.sv
// Block LPC coefficient quantizer: collect, choose shift, emit fixed point.
// Define LPC_QUANT_ERROR_FEEDBACK_EN for FLAC-style error-carry rounding.
module lpc_adaptive_quantizer
    import lpc_quant_pkg::*;
#(
    parameter int PRECISION = 12,
    parameter int MAX_ORDER = 32,
    parameter int MAX_SHIFT = 15,
    parameter int FRAC_BITS = 8
) (
    input logic                     iClock,
    input logic                     iReset,
    input logic                     iEnable,
    lpc_adaptive_quantizer_if.slave bus
);

    localparam int CW = $clog2(MAX_ORDER + 1);
    localparam int IW = $clog2(MAX_ORDER);

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    order;
    logic [CW-1:0]    orderIn;
    logic [CW-1:0]    needed;
    logic [CW-1:0]    rdIdx;
    logic [EXP_W-1:0] emax;
    logic [EXP_W-1:0] inExp;
    logic [31:0]      mem [MAX_ORDER];
    logic [31:0]      rdData;
    logic             rdValid;
    logic             rdLast;
    logic             readyQ;
    logic [4:0]       shiftQ;
    logic [4:0]       sSel;
    int               sCalc;
    logic             accept;
    logic             lastAcc;
    logic             issue;

    assign inExp   = bus.iFloatCoeff[MANT_FRAC_W +: EXP_W];
    assign accept  = iEnable & bus.iValid & readyQ;
    assign needed  = (cnt == '0) ? orderIn : order;
    assign lastAcc = accept && ((cnt + 1'b1) == needed);
    assign issue   = (state == ST_EMIT) && (rdIdx < order);

    always_comb begin
        if (bus.iOrder == '0)
            orderIn = CW'(1);
        else if (int'(bus.iOrder) > MAX_ORDER)
            orderIn = CW'(MAX_ORDER);
        else
            orderIn = CW'(bus.iOrder);
    end

    // emax is biased, so 0 means every coefficient was zero or denormal.
    always_comb begin
        sCalc = PRECISION - 2 - (int'(emax) - EXP_BIAS);
        if (emax == '0 || sCalc < 0)
            sSel = 5'd0;
        else if (sCalc > MAX_SHIFT)
            sSel = 5'(MAX_SHIFT);
        else
            sSel = 5'(sCalc);
    end

    always_comb begin
        stateNext = state;
        unique case (1'b1)
            state == ST_COLLECT: if (lastAcc) stateNext = ST_SHIFT;
            state == ST_SHIFT:   stateNext = ST_EMIT;
            state == ST_EMIT:    if (bus.oValid && bus.oLast) stateNext = ST_COLLECT;
            default:             stateNext = ST_COLLECT;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state   <= ST_COLLECT;
            readyQ  <= 1'b0;
            cnt     <= '0;
            order   <= '0;
            emax    <= '0;
            shiftQ  <= '0;
            rdIdx   <= '0;
            rdValid <= 1'b0;
            rdLast  <= 1'b0;
        end else if (iEnable) begin
            state   <= stateNext;
            readyQ  <= (stateNext == ST_COLLECT);
            rdValid <= issue;
            rdLast  <= issue && (rdIdx == order - 1'b1);
            if (accept) begin
                cnt <= lastAcc ? '0 : cnt + 1'b1;
                if (cnt == '0)
                    order <= orderIn;
                if (inExp > emax)
                    emax <= inExp;
            end
            if (state == ST_SHIFT) begin
                shiftQ <= sSel;
                emax   <= '0;
                rdIdx  <= '0;
            end
            if (issue)
                rdIdx <= rdIdx + 1'b1;
        end
    end

    always_ff @(posedge iClock) begin
        if (accept)
            mem[cnt[IW-1:0]] <= bus.iFloatCoeff;
        if (iEnable && issue)
            rdData <= mem[rdIdx[IW-1:0]];
    end

    assign bus.oReady = readyQ;
    assign bus.oShift = shiftQ;

    float_to_fixed_scaled #(
        .PRECISION (PRECISION),
        .FRAC_BITS (FRAC_BITS)
    ) u_conv (
        .iClock     (iClock),
        .iReset     (iReset),
        .iEnable    (iEnable),
`ifdef LPC_QUANT_ERROR_FEEDBACK_EN
        .iClear     (state == ST_SHIFT),
`endif
        .iValid     (rdValid),
        .iLast      (rdLast),
        .iFloat     (rdData),
        .iShift     (shiftQ),
        .oValid     (bus.oValid),
        .oLast      (bus.oLast),
        .oValue     (bus.oQuantizedCoeff),
        .oSaturated (bus.oSaturated)
    );

endmodule

// File: tb/tb_lpc_adaptive_quantizer.sv
// Directed bench for lpc_adaptive_quantizer (PRECISION 12, FRAC_BITS 8).
// Expected values are hand-computed; third error-carry value follows the macro.
module tb_lpc_adaptive_quantizer;

`ifdef LPC_QUANT_ERROR_FEEDBACK_EN
    localparam int THIRD_TINY = 0;
`else
    localparam int THIRD_TINY = 1;
`endif

    logic iClock = 1'b0;
    logic iReset;
    logic iEnable;
    int   tests  = 0;
    int   failed = 0;

    logic [31:0] coeffs [$];
    int          expVal [$];
    bit          expSat [$];

    lpc_adaptive_quantizer_if #(.PRECISION(12)) bus ();

    lpc_adaptive_quantizer #(
        .PRECISION (12),
        .MAX_ORDER (32),
        .MAX_SHIFT (15),
        .FRAC_BITS (8)
    ) dut (
        .iClock  (iClock),
        .iReset  (iReset),
        .iEnable (iEnable),
        .bus     (bus)
    );

    always #5 iClock = ~iClock;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] f, input int v, input bit s);
        coeffs.push_back(f);
        expVal.push_back(v);
        expSat.push_back(s);
    endtask

    task automatic sendBlock(input logic [5:0] ord);
        int guard;
        foreach (coeffs[i]) begin
            guard = 0;
            while (bus.oReady !== 1'b1 && guard < 20) begin
                tick();
                guard++;
            end
            check("ready_before_send", 32'(bus.oReady), 1);
            bus.iValid      = 1'b1;
            bus.iFloatCoeff = coeffs[i];
            bus.iOrder      = ord;
            tick();
        end
        bus.iValid = 1'b0;
    endtask

    task automatic expectBlock(input logic [4:0] sh, input int stallAt);
        int k;
        int last;
        k    = 0;
        last = expVal.size() - 1;
        while (bus.oValid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("first_valid_latency", k, 4);
        foreach (expVal[i]) begin
            check($sformatf("valid[%0d]", i), 32'(bus.oValid), 1);
            check($sformatf("q[%0d]", i), 32'(bus.oQuantizedCoeff), expVal[i]);
            check($sformatf("sat[%0d]", i), 32'(bus.oSaturated), 32'(expSat[i]));
            check($sformatf("last[%0d]", i), 32'(bus.oLast), 32'(i == last));
            check($sformatf("shift[%0d]", i), 32'(bus.oShift), 32'(sh));
            if (i == stallAt) begin
                iEnable = 1'b0;
                repeat (3) begin
                    tick();
                    check("hold_valid", 32'(bus.oValid), 1);
                    check("hold_q", 32'(bus.oQuantizedCoeff), expVal[i]);
                    check("hold_last", 32'(bus.oLast), 32'(i == last));
                end
                iEnable = 1'b1;
            end
            tick();
        end
        check("valid_after_last", 32'(bus.oValid), 0);
        check("ready_after_last", 32'(bus.oReady), 1);
        coeffs.delete();
        expVal.delete();
        expSat.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iReset          = 1'b1;
        iEnable         = 1'b1;
        bus.iValid      = 1'b0;
        bus.iFloatCoeff = '0;
        bus.iOrder      = '0;
        repeat (3) tick();
        check("rst_ready", 32'(bus.oReady), 0);
        check("rst_valid", 32'(bus.oValid), 0);
        check("rst_q", 32'(bus.oQuantizedCoeff), 0);
        check("rst_shift", 32'(bus.oShift), 0);
        check("rst_last", 32'(bus.oLast), 0);
        check("rst_sat", 32'(bus.oSaturated), 0);
        iReset = 1'b0;
        tick();
        check("ready_after_rst", 32'(bus.oReady), 1);

        // 0.5 -> s=11, 1024
        push(32'h3F000000, 1024, 0);
        sendBlock(6'd1);
        expectBlock(5'd11, -1);

        // 1.5, -0.75 -> s=10
        push(32'h3FC00000, 1536, 0);
        push(32'hBF400000, -768, 0);
        sendBlock(6'd2);
        expectBlock(5'd10, -1);

        // all zero -> s=0
        repeat (4) push(32'h00000000, 0, 0);
        sendBlock(6'd4);
        expectBlock(5'd0, -1);

        // 5000.0 -> s clamped to 0, saturates
        push(32'h459C4000, 2047, 1);
        sendBlock(6'd1);
        expectBlock(5'd0, -1);

        // 0.001 -> s clamped to 15, 33
        push(32'h3A83126F, 33, 0);
        sendBlock(6'd1);
        expectBlock(5'd15, -1);

        // 1.0, 2^-11, 2^-11 -> s=10
        push(32'h3F800000, 1024, 0);
        push(32'h3A000000, 1, 0);
        push(32'h3A000000, THIRD_TINY, 0);
        sendBlock(6'd3);
        expectBlock(5'd10, -1);

        // -inf saturates negative, s=0
        push(32'hFF800000, -2048, 1);
        sendBlock(6'd1);
        expectBlock(5'd0, -1);

        // order 0 treated as 1: -1.0 -> s=10
        push(32'hBF800000, -1024, 0);
        sendBlock(6'd0);
        expectBlock(5'd10, -1);

        // reset after 2 of 4 accepts aborts the block
        coeffs.push_back(32'h3F800000);
        coeffs.push_back(32'h3F000000);
        sendBlock(6'd4);
        coeffs.delete();
        iReset = 1'b1;
        tick();
        check("abort_valid_in_rst", 32'(bus.oValid), 0);
        iReset = 1'b0;
        tick();
        check("abort_ready", 32'(bus.oReady), 1);
        repeat (6) begin
            check("abort_no_valid", 32'(bus.oValid), 0);
            tick();
        end
        push(32'h3F000000, 1024, 0);
        sendBlock(6'd1);
        expectBlock(5'd11, -1);

        // iEnable low for 3 cycles mid-emit
        push(32'h3F000000, 1024, 0);
        push(32'h3E800000, 512, 0);
        push(32'hBF000000, -1024, 0);
        sendBlock(6'd3);
        expectBlock(5'd11, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
